// File: rtl/r_empty_gray.sv
// r_empty_gray: read-side pointer, synchroniser and status flags for the dual-clock FIFO
module r_empty_gray #(
  parameter int ADDR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  rclk,
  input  logic                  rrstn,
  input  logic                  ren,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic                  underflow_clr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  runderflow
);
  localparam logic [ADDR_WIDTH:0] AE_THRESH = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] sync_d [SYNC_STAGES];
  logic [ADDR_WIDTH:0] wq_gray, wq_bin;
  logic [ADDR_WIDTH:0] rbin_q, rbin_d, rptr_gray_q, rptr_gray_d, rlevel_q, rlevel_d;
  logic                rempty_q, rempty_d, raempty_q, raempty_d, runderflow_q, runderflow_d;
  logic                rd;
  // shift the write pointer through the synchroniser chain and decode it to binary
  always_comb begin
    sync_d[0] = wptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    wq_gray = sync_q[SYNC_STAGES-1];
    for (int i = 0; i <= ADDR_WIDTH; i++) wq_bin[i] = ^(wq_gray >> i);
  end
  // advance the read pointer on accepted reads and derive next-cycle status from it
  always_comb begin
    rd           = ren & ~rempty_q;
    rbin_d       = rbin_q + {{ADDR_WIDTH{1'b0}}, rd};
    rptr_gray_d  = rbin_d ^ (rbin_d >> 1);
    rempty_d     = rptr_gray_d == wq_gray;
    rlevel_d     = wq_bin - rbin_d;
    raempty_d    = rlevel_d <= AE_THRESH;
    runderflow_d = (ren & rempty_q) | (runderflow_q & ~underflow_clr);
  end
  // synchroniser flops, cleared asynchronously
  always_ff @(posedge rclk or negedge rrstn)
    if (!rrstn) for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
  // pointer and status registers, empty/almost-empty asserted out of reset
  always_ff @(posedge rclk or negedge rrstn)
    if (!rrstn) begin
      rbin_q       <= '0;
      rptr_gray_q  <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_gray_q  <= rptr_gray_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      rlevel_q     <= rlevel_d;
      runderflow_q <= runderflow_d;
    end
  assign rptr_gray  = rptr_gray_q;
  assign raddr      = rbin_q[ADDR_WIDTH-1:0];
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;
endmodule
